mdu_iter: RTL

- Parametrised successor of the pipeline multiply/divide unit. Used in the E stage; owns the HI/LO registers.
- Replaces fixed-delay behavioural arithmetic with real iterative hardware: radix-2 shift-add multiply and restoring divide, one bit per cycle.
- Provides the same busy/stall handshake towards the D stage, exception cancel via req, and mfhi/mflo/mthi/mtlo.

---
 rtl/mdu_pkg.sv | 63 ++++++
 rtl/mdu_iter_if.sv | 24 ++
 rtl/mdu_iter_core.sv | 77 +++++++
 rtl/mdu_iter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared op-code constants, FSM state encoding and op-decode helpers for the iterative MDU.
// Optional multiply-accumulate ops are gated by the MDU_MADD_EN macro.
package mdu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  function automatic logic is_madd_op(input logic [3:0] op);
    return (op == OP_MADD) || (op == OP_MADDU);
  endfunction

  function automatic logic is_msub_op(input logic [3:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_start_op(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    r = r || is_madd_op(op) || is_msub_op(op);
`endif
    return r;
  endfunction

  // With the accumulate feature off, its reserved codes behave exactly like NOP.
  function automatic logic is_nop_op(input logic [3:0] op);
    logic r;
    r = (op == OP_NOP);
`ifndef MDU_MADD_EN
    r = r || is_madd_op(op) || is_msub_op(op);
`endif
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_DIV);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MSUB);
`endif
    return r;
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// D/E-stage facing bus of the iterative MDU: op codes, operands, flush and the
// read-back / busy / stall responses.
interface mdu_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic [3:0]       op_d;
  logic [3:0]       op_e;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             req;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             stall;

  modport master (
    output op_d, op_e, data1, data2, req,
    input  out, busy, stall
  );

  modport slave (
    input  op_d, op_e, data1, data2, req,
    output out, busy, stall
  );
endinterface

// File: rtl/mdu_iter_core.sv
// Radix-2 datapath: shift-add multiply or restoring divide on magnitudes, one bit per
// step, plus the iteration counter. {acc_hi, acc_lo} is the product or {rem, quot}.
module mdu_iter_core #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             div_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo,
  output logic             last
);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_s;
  logic             ge;

  always_comb begin
    sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : '0)};
    rem_s = {hi_q, lo_q[WIDTH-1]};
    ge    = rem_s >= {1'b0, m_q};

    hi_d  = hi_q;
    lo_d  = lo_q;
    m_d   = m_q;
    div_d = div_q;
    cnt_d = cnt_q;

    if (load) begin
      // Multiply keeps the multiplier in lo; divide keeps the dividend there.
      hi_d  = '0;
      lo_d  = div_op ? op_a : op_b;
      m_d   = div_op ? op_b : op_a;
      div_d = div_op;
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (div_q) begin
        // rem < 2*divisor, so the difference always fits back into WIDTH bits.
        hi_d = ge ? (rem_s[WIDTH-1:0] - m_q) : rem_s[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], ge};
      end else begin
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      m_q   <= m_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_hi = hi_q;
  assign acc_lo = lo_q;
  assign last   = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mdu_iter.sv
// Iterative E-stage multiply/divide unit owning HI/LO, with D-stage stall and mf/mt access.
// Define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input logic        clk,
  input logic        reset,
  mdu_iter_if.slave  bus
);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [3:0]         op_q, op_nxt;
  logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, div_zero_q, div_zero_d;

  logic               busy, start, sgn, neg_a, neg_b, core_last;
  logic [WIDTH-1:0]   abs_a, abs_b, acc_hi, acc_lo;
  logic [2*WIDTH-1:0] prod_fix;

  assign busy  = (state_q != ST_IDLE);
  assign start = is_start_op(bus.op_e) && !busy && !bus.req;

  assign sgn   = is_signed_op(bus.op_e);
  assign neg_a = sgn & bus.data1[WIDTH-1];
  assign neg_b = sgn & bus.data2[WIDTH-1];
  assign abs_a = neg_a ? -bus.data1 : bus.data1;
  assign abs_b = neg_b ? -bus.data2 : bus.data2;

  mdu_iter_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (start),
    .step   (state_q == ST_CALC),
    .div_op (is_div_op(bus.op_e)),
    .op_a   (abs_a),
    .op_b   (abs_b),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .last   (core_last)
  );

  assign prod_fix = neg_res_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    op_nxt     = op_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_CALC;
          op_nxt     = bus.op_e;
          neg_res_d  = neg_a ^ neg_b;
          neg_rem_d  = neg_a & is_div_op(bus.op_e);
          div_zero_d = (bus.data2 == '0);
        end else if (!bus.req) begin
          if (bus.op_e == OP_MTHI) hi_d = bus.data1;
          if (bus.op_e == OP_MTLO) lo_d = bus.data1;
        end
      end
      ST_CALC: begin
        if (core_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (is_div_op(op_q)) begin
          // Divide by zero leaves the (re-signed) dividend in HI and forces LO to all ones.
          hi_d = neg_rem_q ? -acc_hi : acc_hi;
          lo_d = div_zero_q ? '1 : (neg_res_q ? -acc_lo : acc_lo);
        end else begin
`ifdef MDU_MADD_EN
          if (is_madd_op(op_q))      {hi_d, lo_d} = {hi_q, lo_q} + prod_fix;
          else if (is_msub_op(op_q)) {hi_d, lo_d} = {hi_q, lo_q} - prod_fix;
          else                       {hi_d, lo_d} = prod_fix;
`else
          {hi_d, lo_d} = prod_fix;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      op_q       <= OP_NOP;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      op_q       <= op_nxt;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_comb begin
    bus.out = '0;
    if (bus.op_e == OP_MFHI)      bus.out = hi_q;
    else if (bus.op_e == OP_MFLO) bus.out = lo_q;
  end

  assign bus.busy  = busy;
  assign bus.stall = (busy || is_start_op(bus.op_e)) && !is_nop_op(bus.op_d);

endmodule
